// File: rtl/vga_mode_ctrl_if.sv
// Mode request channel for vga_mode_ctrl: a valid/ready handshake that carries
// the eight requested horizontal/vertical timing fields.
interface vga_mode_ctrl_if #(
    parameter int HW = 12,
    parameter int VW = 12
);
    logic          i_mode_valid;
    logic          o_mode_ready;
    logic [HW-1:0] i_hm_width;
    logic [HW-1:0] i_hm_porch;
    logic [HW-1:0] i_hm_synch;
    logic [HW-1:0] i_hm_raw;
    logic [VW-1:0] i_vm_height;
    logic [VW-1:0] i_vm_porch;
    logic [VW-1:0] i_vm_synch;
    logic [VW-1:0] i_vm_raw;

    modport master (
        output i_mode_valid,
        output i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw,
        output i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw,
        input  o_mode_ready
    );

    modport slave (
        input  i_mode_valid,
        input  i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw,
        input  i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw,
        output o_mode_ready
    );
endinterface

// File: rtl/vga_mode_ctrl.sv
// VGA mode controller: buffers a mode request and applies it at the next frame boundary,
// holding the timing generator in reset while switching. Optional MODE_CHECK_EN rejects malformed modes.
module vga_mode_ctrl #(
    parameter int HW          = 12,
    parameter int VW          = 12,
    parameter int HOLD_CYCLES = 4,
    parameter int DEF_HW      = 640,
    parameter int DEF_HP      = 656,
    parameter int DEF_HS      = 752,
    parameter int DEF_HR      = 800,
    parameter int DEF_VH      = 480,
    parameter int DEF_VP      = 490,
    parameter int DEF_VS      = 492,
    parameter int DEF_VR      = 525
) (
    input  logic                 i_pixclk,
    input  logic                 i_reset_n,
    vga_mode_ctrl_if.slave       req,
    input  logic                 i_newframe,
    output logic [HW-1:0]        o_hm_width,
    output logic [HW-1:0]        o_hm_porch,
    output logic [HW-1:0]        o_hm_synch,
    output logic [HW-1:0]        o_hm_raw,
    output logic [VW-1:0]        o_vm_height,
    output logic [VW-1:0]        o_vm_porch,
    output logic [VW-1:0]        o_vm_synch,
    output logic [VW-1:0]        o_vm_raw,
    output logic                 o_vga_reset,
    output logic                 o_busy,
    output logic                 o_err,
    output logic [7:0]           o_changes
);
    typedef enum logic [1:0] {IDLE, PEND, LOAD, HOLD} state_t;

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

    state_t        state, state_nx;
    logic [7:0]    hold_cnt;
    logic          mode_ready;
    logic          req_ok;
    logic [HW-1:0] sh_hm_width, sh_hm_porch, sh_hm_synch, sh_hm_raw;
    logic [VW-1:0] sh_vm_height, sh_vm_porch, sh_vm_synch, sh_vm_raw;

    assign req.o_mode_ready = mode_ready;

    // Reset parks the FSM in HOLD so the timing generator stays in reset for HOLD_CYCLES after release.
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= HOLD;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        mode_ready  = 1'b0;
        o_busy      = 1'b1;
        o_vga_reset = 1'b0;
        case (state)
            IDLE: begin
                mode_ready = 1'b1;
                o_busy     = 1'b0;
                if (req.i_mode_valid) state_nx = PEND;
            end
            PEND: begin
                if (!req_ok)         state_nx = IDLE;
                else if (i_newframe) state_nx = LOAD;
            end
            LOAD: begin
                o_vga_reset = 1'b1;
                state_nx    = HOLD;
            end
            HOLD: begin
                o_vga_reset = 1'b1;
                if (hold_cnt == 8'd0) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold_cnt     <= HOLD_INIT;
            o_changes    <= 8'd0;
            o_hm_width   <= HW'(DEF_HW);
            o_hm_porch   <= HW'(DEF_HP);
            o_hm_synch   <= HW'(DEF_HS);
            o_hm_raw     <= HW'(DEF_HR);
            o_vm_height  <= VW'(DEF_VH);
            o_vm_porch   <= VW'(DEF_VP);
            o_vm_synch   <= VW'(DEF_VS);
            o_vm_raw     <= VW'(DEF_VR);
            sh_hm_width  <= '0;
            sh_hm_porch  <= '0;
            sh_hm_synch  <= '0;
            sh_hm_raw    <= '0;
            sh_vm_height <= '0;
            sh_vm_porch  <= '0;
            sh_vm_synch  <= '0;
            sh_vm_raw    <= '0;
        end else begin
            if (mode_ready && req.i_mode_valid) begin
                sh_hm_width  <= req.i_hm_width;
                sh_hm_porch  <= req.i_hm_porch;
                sh_hm_synch  <= req.i_hm_synch;
                sh_hm_raw    <= req.i_hm_raw;
                sh_vm_height <= req.i_vm_height;
                sh_vm_porch  <= req.i_vm_porch;
                sh_vm_synch  <= req.i_vm_synch;
                sh_vm_raw    <= req.i_vm_raw;
            end
            // The active mode only ever moves here, while the generator is held in reset.
            if (state == LOAD) begin
                o_hm_width  <= sh_hm_width;
                o_hm_porch  <= sh_hm_porch;
                o_hm_synch  <= sh_hm_synch;
                o_hm_raw    <= sh_hm_raw;
                o_vm_height <= sh_vm_height;
                o_vm_porch  <= sh_vm_porch;
                o_vm_synch  <= sh_vm_synch;
                o_vm_raw    <= sh_vm_raw;
                o_changes   <= o_changes + 8'd1;
                hold_cnt    <= HOLD_INIT;
            end else if (state == HOLD && hold_cnt != 8'd0) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

`ifdef MODE_CHECK_EN
    assign req_ok = (sh_hm_width  > HW'(16))   && (sh_hm_width  < sh_hm_porch) &&
                    (sh_hm_porch  < sh_hm_synch) && (sh_hm_synch < sh_hm_raw)  &&
                    (sh_vm_height > VW'(16))   && (sh_vm_height < sh_vm_porch) &&
                    (sh_vm_porch  < sh_vm_synch) && (sh_vm_synch < sh_vm_raw);

    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_err <= 1'b0;
        end else if (state == PEND) begin
            o_err <= !req_ok;
        end
    end
`else
    assign req_ok = 1'b1;
    assign o_err  = 1'b0;
`endif

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Scoreboard bench for vga_mode_ctrl: accepted requests are queued and compared
// against the active mode after each frame-boundary load.
module tb_vga_mode_ctrl;
    localparam int HOLD_CYCLES = 4;

    typedef struct packed {
        logic [3:0][11:0] h;
        logic [3:0][11:0] v;
    } mode_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        newframe;
    logic [11:0] o_hm_width, o_hm_porch, o_hm_synch, o_hm_raw;
    logic [11:0] o_vm_height, o_vm_porch, o_vm_synch, o_vm_raw;
    logic        o_vga_reset, o_busy, o_err;
    logic [7:0]  o_changes;

    int          checks = 0;
    int          errors = 0;
    mode_t       sb[$];
    mode_t       cur_mode;
    mode_t       def_mode;
    mode_t       dut_mode;
    logic [7:0]  exp_changes;

    vga_mode_ctrl_if #(.HW(12), .VW(12)) req_if ();

    vga_mode_ctrl #(.HOLD_CYCLES(HOLD_CYCLES)) dut (
        .i_pixclk    (clk),
        .i_reset_n   (rst_n),
        .req         (req_if),
        .i_newframe  (newframe),
        .o_hm_width  (o_hm_width),
        .o_hm_porch  (o_hm_porch),
        .o_hm_synch  (o_hm_synch),
        .o_hm_raw    (o_hm_raw),
        .o_vm_height (o_vm_height),
        .o_vm_porch  (o_vm_porch),
        .o_vm_synch  (o_vm_synch),
        .o_vm_raw    (o_vm_raw),
        .o_vga_reset (o_vga_reset),
        .o_busy      (o_busy),
        .o_err       (o_err),
        .o_changes   (o_changes)
    );

    always #5 clk = ~clk;

    always_comb begin
        dut_mode.h = {o_hm_raw, o_hm_synch, o_hm_porch, o_hm_width};
        dut_mode.v = {o_vm_raw, o_vm_synch, o_vm_porch, o_vm_height};
    end

    function automatic mode_t mk(input int w, p, s, r, hh, vp, vs, vr);
        mode_t m;
        m.h = {12'(r), 12'(s), 12'(p), 12'(w)};
        m.v = {12'(vr), 12'(vs), 12'(vp), 12'(hh)};
        return m;
    endfunction

    task automatic drive_fields(input mode_t m);
        req_if.i_hm_width  = m.h[0];
        req_if.i_hm_porch  = m.h[1];
        req_if.i_hm_synch  = m.h[2];
        req_if.i_hm_raw    = m.h[3];
        req_if.i_vm_height = m.v[0];
        req_if.i_vm_porch  = m.v[1];
        req_if.i_vm_synch  = m.v[2];
        req_if.i_vm_raw    = m.v[3];
    endtask

    // Waits for ready, hands over one request and queues it when it should reach the outputs.
    task automatic send_request(input mode_t m, input bit will_apply);
        int n = 0;
        while (req_if.o_mode_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_if.o_mode_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL req_ready got %b want 1", req_if.o_mode_ready);
        end
        drive_fields(m);
        req_if.i_mode_valid = 1'b1;
        if (will_apply) sb.push_back(m);
        @(negedge clk);
        req_if.i_mode_valid = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || req_if.o_mode_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL accept_busy got busy=%b ready=%b want busy=1 ready=0", o_busy, req_if.o_mode_ready);
        end
    endtask

    task automatic apply_frame();
        int    n = 0;
        mode_t exp;
        newframe = 1'b1;
        @(negedge clk);
        newframe = 1'b0;
        while (o_vga_reset === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != HOLD_CYCLES + 1) begin
            errors++;
            $display("[TB] FAIL vga_reset_len got %0d want %0d", n, HOLD_CYCLES + 1);
        end
        exp_changes = exp_changes + 8'd1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard got empty queue want pending entry");
        end else begin
            exp = sb.pop_front();
            cur_mode = exp;
            if (dut_mode !== exp) begin
                errors++;
                $display("[TB] FAIL applied_mode got %h want %h", dut_mode, exp);
            end
        end
        checks++;
        if (o_changes !== exp_changes) begin
            errors++;
            $display("[TB] FAIL changes got %0d want %0d", o_changes, exp_changes);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_if.o_mode_ready !== 1'b0 || o_busy !== 1'b1 || o_vga_reset !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got ready=%b busy=%b vrst=%b want 0 1 1", req_if.o_mode_ready, o_busy, o_vga_reset);
        end
        checks++;
        if (o_err !== 1'b0 || o_changes !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_err_cnt got err=%b changes=%0d want 0 0", o_err, o_changes);
        end
        checks++;
        if (dut_mode !== def_mode) begin
            errors++;
            $display("[TB] FAIL reset_mode got %h want %h", dut_mode, def_mode);
        end
        rst_n = 1'b1;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (o_vga_reset === 1'b0) break;
        end
        checks++;
        if (n != HOLD_CYCLES) begin
            errors++;
            $display("[TB] FAIL release_hold got %0d want %0d", n, HOLD_CYCLES);
        end
        checks++;
        if (req_if.o_mode_ready !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL release_idle got ready=%b busy=%b want 1 0", req_if.o_mode_ready, o_busy);
        end
        checks++;
        if (dut_mode !== def_mode || o_changes !== 8'd0) begin
            errors++;
            $display("[TB] FAIL release_mode got %h/%0d want %h/0", dut_mode, o_changes, def_mode);
        end
    endtask

    task automatic test_mode_change();
        send_request(mk(800, 840, 968, 1056, 600, 601, 605, 628), 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (dut_mode !== cur_mode || o_vga_reset !== 1'b0) begin
                errors++;
                $display("[TB] FAIL pend_stable got %h vrst=%b want %h vrst=0", dut_mode, o_vga_reset, cur_mode);
            end
        end
        apply_frame();
    endtask

    task automatic test_coincident();
        drive_fields(mk(1024, 1048, 1184, 1344, 768, 771, 777, 806));
        sb.push_back(mk(1024, 1048, 1184, 1344, 768, 771, 777, 806));
        req_if.i_mode_valid = 1'b1;
        newframe = 1'b1;
        @(negedge clk);
        req_if.i_mode_valid = 1'b0;
        newframe = 1'b0;
        drive_fields(mk(320, 336, 384, 400, 240, 245, 247, 262));
        req_if.i_mode_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (dut_mode !== cur_mode || o_vga_reset !== 1'b0 || req_if.o_mode_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL coincident_hold got %h vrst=%b ready=%b want %h 0 0", dut_mode, o_vga_reset, req_if.o_mode_ready, cur_mode);
            end
        end
        req_if.i_mode_valid = 1'b0;
        apply_frame();
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ignored_req busy got %b want 0", o_busy);
        end
    endtask

    task automatic test_mode_check();
`ifdef MODE_CHECK_EN
        send_request(mk(700, 656, 752, 800, 480, 490, 492, 525), 1'b0);
        @(negedge clk);
        checks++;
        if (o_err !== 1'b1 || req_if.o_mode_ready !== 1'b1 || o_vga_reset !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reject got err=%b ready=%b vrst=%b want 1 1 0", o_err, req_if.o_mode_ready, o_vga_reset);
        end
        newframe = 1'b1;
        @(negedge clk);
        newframe = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_mode !== cur_mode || o_changes !== exp_changes || o_vga_reset !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reject_mode got %h/%0d want %h/%0d", dut_mode, o_changes, cur_mode, exp_changes);
        end
        send_request(mk(640, 656, 752, 800, 480, 490, 492, 525), 1'b1);
        @(negedge clk);
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_clear got %b want 0", o_err);
        end
        apply_frame();
`else
        send_request(mk(700, 656, 752, 800, 480, 490, 492, 525), 1'b1);
        @(negedge clk);
        checks++;
        if (o_err !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL nocheck_pend got err=%b busy=%b want 0 1", o_err, o_busy);
        end
        apply_frame();
        checks++;
        if (o_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nocheck_err got %b want 0", o_err);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int n = 0;
        send_request(mk(1024, 1048, 1184, 1344, 768, 771, 777, 806), 1'b1);
        newframe = 1'b1;
        @(negedge clk);
        newframe = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        cur_mode = def_mode;
        exp_changes = 8'd0;
        checks++;
        if (dut_mode !== def_mode || o_vga_reset !== 1'b1 || o_changes !== 8'd0) begin
            errors++;
            $display("[TB] FAIL midreset got %h vrst=%b changes=%0d want %h 1 0", dut_mode, o_vga_reset, o_changes, def_mode);
        end
        @(negedge clk);
        rst_n = 1'b1;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (o_vga_reset === 1'b0) break;
        end
        checks++;
        if (n != HOLD_CYCLES || dut_mode !== def_mode) begin
            errors++;
            $display("[TB] FAIL midreset_release got n=%0d mode=%h want %0d %h", n, dut_mode, HOLD_CYCLES, def_mode);
        end
    endtask

    // Back-to-back requests, each issued as soon as ready returns, until the change counter wraps.
    task automatic test_back_to_back();
        int w, p, s, r, hh, vp, vs, vr;
        for (int i = 0; i < 256; i++) begin
            w  = 17 + int'($urandom_range(200));
            p  = w + 1 + int'($urandom_range(50));
            s  = p + 1 + int'($urandom_range(100));
            r  = s + 1 + int'($urandom_range(200));
            hh = 17 + int'($urandom_range(200));
            vp = hh + 1 + int'($urandom_range(20));
            vs = vp + 1 + int'($urandom_range(10));
            vr = vs + 1 + int'($urandom_range(50));
            send_request(mk(w, p, s, r, hh, vp, vs, vr), 1'b1);
            apply_frame();
        end
        checks++;
        if (o_changes !== 8'd0) begin
            errors++;
            $display("[TB] FAIL wrap got %0d want 0", o_changes);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        newframe = 1'b0;
        req_if.i_mode_valid = 1'b0;
        def_mode = mk(640, 656, 752, 800, 480, 490, 492, 525);
        cur_mode = def_mode;
        exp_changes = 8'd0;
        drive_fields(def_mode);
        test_reset();
        test_mode_change();
        test_coincident();
        test_mode_check();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
